max_pool_2x2_stream: RTL

- Streaming 2x2, stride-2 max-pooling stage for IEEE-754 single-precision feature maps. It sits directly downstream of a convolution/ReLU output and upstream of the next layer.
- Consumes one pixel per valid cycle in raster order and buffers one half-width row of horizontal maxima.
- Emits one pooled pixel per 2x2 window, in raster order of the pooled map.
- Float comparisons use the same ordering as the Max_Value comparator.

---
 rtl/max_pool_2x2_stream_if.sv | 10 +
 rtl/max_pool_2x2_stream.sv | 78 +++++++
 2 files changed

// File: rtl/max_pool_2x2_stream_if.sv
// max_pool_2x2_stream_if: raster pixel stream in, pooled pixel stream out
interface max_pool_2x2_stream_if #(parameter int data_width = 32);
    logic                  in_valid;
    logic [data_width-1:0] in_data;
    logic                  out_valid;
    logic [data_width-1:0] out_data;
    logic                  frame_done;
    modport master (output in_valid, in_data, input out_valid, out_data, frame_done);
    modport slave  (input in_valid, in_data, output out_valid, out_data, frame_done);
endinterface

// File: rtl/max_pool_2x2_stream.sv
// max_pool_2x2_stream: streaming 2x2 stride-2 max pooling of IEEE-754 float feature maps
module max_pool_2x2_stream #(
    parameter int data_width = 32,
    parameter int img_width  = 8,
    parameter int img_height = 8
) (
    input logic clk,
    input logic rst,
    max_pool_2x2_stream_if.slave bus
);
    localparam int cw = $clog2(img_width);
    localparam int rw = $clog2(img_height);
    localparam int hw = img_width / 2;
    localparam int iw = hw > 1 ? $clog2(hw) : 1;
    localparam logic [0:0] EVEN_ROW = 1'b0;
    localparam logic [0:0] ODD_ROW  = 1'b1;

    // Maps a float onto an unsigned key whose order matches the float order (-0.0 < +0.0)
    function automatic logic [data_width-1:0] fkey(input logic [data_width-1:0] x);
        return x[data_width-1] ? ~x : x ^ {1'b1, {(data_width-1){1'b0}}};
    endfunction

    function automatic logic [data_width-1:0] fmax(input logic [data_width-1:0] a, input logic [data_width-1:0] b);
        return fkey(b) > fkey(a) ? b : a;
    endfunction

    logic [cw-1:0]         col;
    logic [rw-1:0]         row;
    logic [0:0]            state;
    logic [data_width-1:0] h_reg;
    logic [data_width-1:0] out_q;
    logic                  vld_q;
    logic                  fd_q;
    logic [data_width-1:0] linebuf [hw];
    logic [iw-1:0]         idx;
    logic [data_width-1:0] hmax;
    logic [data_width-1:0] vmax;
    logic                  last_col;
    logic                  last_row;

    assign idx      = iw'(col >> 1);
    assign hmax     = fmax(h_reg, bus.in_data);
    assign vmax     = fmax(linebuf[idx], hmax);
    assign last_col = col == cw'(img_width - 1);
    assign last_row = row == rw'(img_height - 1);

    // Outputs are masked by rst so a pulse pending in the reset cycle never reaches downstream
    assign bus.out_valid  = vld_q & ~rst;
    assign bus.out_data   = rst ? '0 : out_q;
    assign bus.frame_done = fd_q & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            col   <= '0;
            row   <= '0;
            state <= EVEN_ROW;
            h_reg <= '0;
            out_q <= '0;
            vld_q <= 1'b0;
            fd_q  <= 1'b0;
        end else begin
            vld_q <= bus.in_valid & col[0] & (state == ODD_ROW);
            fd_q  <= bus.in_valid & last_col & last_row & (state == ODD_ROW);
            if (bus.in_valid) begin
                if (!col[0]) h_reg <= bus.in_data;
                if (col[0] && state == ODD_ROW) out_q <= vmax;
                col <= last_col ? '0 : col + 1'b1;
                if (last_col) begin
                    row   <= last_row ? '0 : row + 1'b1;
                    state <= state == EVEN_ROW ? ODD_ROW : EVEN_ROW;
                end
            end
        end
    end

    always_ff @(posedge clk)
        if (!rst && bus.in_valid && col[0] && state == EVEN_ROW) linebuf[idx] <= hmax;
endmodule
